// File: rtl/uop_dispatch.sv
// uop_dispatch: single-entry micro-op dispatch register with register/flag busy scoreboard
// and one-hot issue to the functional unit selected by the FU code.
module uop_dispatch #(
    parameter int NUM_FU_P         = 6,
    parameter int WIDTH_FU_P       = 3,
    parameter int NUM_REGS_P       = 16,
    parameter int REG_ADDR_WIDTH_P = 4,
    parameter int NUM_FLAGS_P      = 4,
    parameter int PAYLOAD_WIDTH_P  = 32
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        uop_v_i,
    output logic                        uop_ready_o,
    input  logic                        uop_we_i,
    input  logic [WIDTH_FU_P-1:0]       uop_fu_i,
    input  logic [NUM_FLAGS_P-1:0]      uop_flags_w_i,
    input  logic [NUM_FLAGS_P-1:0]      uop_flags_r_i,
    input  logic [REG_ADDR_WIDTH_P-1:0] uop_dest_i,
    input  logic [REG_ADDR_WIDTH_P-1:0] uop_s1_i,
    input  logic                        uop_s1_v_i,
    input  logic [REG_ADDR_WIDTH_P-1:0] uop_s2_i,
    input  logic                        uop_s2_v_i,
    input  logic [PAYLOAD_WIDTH_P-1:0]  uop_payload_i,
    output logic [NUM_FU_P-1:0]         issue_v_o,
    input  logic [NUM_FU_P-1:0]         fu_ready_i,
    output logic [REG_ADDR_WIDTH_P-1:0] issue_dest_o,
    output logic                        issue_we_o,
    output logic [NUM_FLAGS_P-1:0]      issue_flags_w_o,
    output logic [PAYLOAD_WIDTH_P-1:0]  issue_payload_o,
    input  logic                        wb_v_i,
    input  logic                        wb_we_i,
    input  logic [REG_ADDR_WIDTH_P-1:0] wb_dest_i,
    input  logic [NUM_FLAGS_P-1:0]      wb_flags_i,
    input  logic                        flush_i,
    output logic [15:0]                 stall_cnt_o
);
    localparam logic [WIDTH_FU_P:0] FU_LIM = (WIDTH_FU_P+1)'(NUM_FU_P);

    logic                        held_v, h_we, h_s1_v, h_s2_v;
    logic [WIDTH_FU_P-1:0]       h_fu;
    logic [NUM_FLAGS_P-1:0]      h_flags_w, h_flags_r, fbusy, fbusy_set, fbusy_clr;
    logic [REG_ADDR_WIDTH_P-1:0] h_dest, h_s1, h_s2;
    logic [PAYLOAD_WIDTH_P-1:0]  h_payload;
    logic [NUM_REGS_P-1:0]       busy, busy_set, busy_clr;
    logic [15:0]                 stall_cnt;
    logic                        fu_ok, hazard, fire, accept, stall;

    // Hazards look only at registered busy state, so a writeback wakes a waiter one cycle later.
    assign fu_ok  = {1'b0, h_fu} < FU_LIM;
    assign hazard = (h_s1_v && busy[h_s1]) || (h_s2_v && busy[h_s2]) || (h_we && busy[h_dest]) ||
                    |((h_flags_r | h_flags_w) & fbusy);
    assign issue_v_o = (held_v && !hazard && fu_ok) ? NUM_FU_P'(1) << h_fu : '0;
    // Out-of-range FU codes retire immediately as NOPs without touching the scoreboard.
    assign fire   = held_v && !flush_i && (fu_ok ? |(issue_v_o & fu_ready_i) : 1'b1);
    assign uop_ready_o = !flush_i && (!held_v || fire);
    assign accept = uop_v_i && uop_ready_o;
    assign stall  = held_v && !fire && !flush_i;

    assign busy_set  = (fire && fu_ok && h_we) ? NUM_REGS_P'(1) << h_dest : '0;
    assign busy_clr  = (wb_v_i && wb_we_i) ? NUM_REGS_P'(1) << wb_dest_i : '0;
    assign fbusy_set = (fire && fu_ok) ? h_flags_w : '0;
    assign fbusy_clr = wb_v_i ? wb_flags_i : '0;

    assign issue_dest_o    = h_dest;
    assign issue_we_o      = h_we;
    assign issue_flags_w_o = h_flags_w;
    assign issue_payload_o = h_payload;
    assign stall_cnt_o     = stall_cnt;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            held_v    <= 1'b0;
            h_we      <= 1'b0;
            h_fu      <= '0;
            h_flags_w <= '0;
            h_flags_r <= '0;
            h_dest    <= '0;
            h_s1      <= '0;
            h_s1_v    <= 1'b0;
            h_s2      <= '0;
            h_s2_v    <= 1'b0;
            h_payload <= '0;
            busy      <= '0;
            fbusy     <= '0;
            stall_cnt <= '0;
        end else begin
            held_v <= accept || stall;
            if (accept) begin
                h_we      <= uop_we_i;
                h_fu      <= uop_fu_i;
                h_flags_w <= uop_flags_w_i;
                h_flags_r <= uop_flags_r_i;
                h_dest    <= uop_dest_i;
                h_s1      <= uop_s1_i;
                h_s1_v    <= uop_s1_v_i;
                h_s2      <= uop_s2_i;
                h_s2_v    <= uop_s2_v_i;
                h_payload <= uop_payload_i;
            end
            busy  <= (busy & ~busy_clr) | busy_set;
            fbusy <= (fbusy & ~fbusy_clr) | fbusy_set;
            if (stall && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_uop_dispatch.sv
// tb_uop_dispatch: directed plus random stimulus; accepted micro-ops queue in a scoreboard and a
// monitor pops them on dispatch, checking issue timing against a behavioural hazard model.
module tb_uop_dispatch;
    typedef struct {
        logic        we;
        logic [2:0]  fu;
        logic [3:0]  fw, fr, dest, s1, s2;
        logic        s1v, s2v;
        logic [31:0] pl;
    } uop_t;

    logic        clk_i, reset_n_i, uop_v_i, uop_ready_o, uop_we_i, uop_s1_v_i, uop_s2_v_i;
    logic [2:0]  uop_fu_i;
    logic [3:0]  uop_flags_w_i, uop_flags_r_i, uop_dest_i, uop_s1_i, uop_s2_i;
    logic [31:0] uop_payload_i, issue_payload_o;
    logic [5:0]  issue_v_o, fu_ready_i;
    logic [3:0]  issue_dest_o, issue_flags_w_o, wb_dest_i, wb_flags_i;
    logic        issue_we_o, wb_v_i, wb_we_i, flush_i;
    logic [15:0] stall_cnt_o;

    int checks = 0, failures = 0;
    uop_t exp_q[$];
    bit   rb[16];
    logic [3:0]  fb = '0;
    logic [15:0] stall = '0;

    uop_dispatch dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .uop_v_i(uop_v_i), .uop_ready_o(uop_ready_o),
        .uop_we_i(uop_we_i), .uop_fu_i(uop_fu_i), .uop_flags_w_i(uop_flags_w_i),
        .uop_flags_r_i(uop_flags_r_i), .uop_dest_i(uop_dest_i), .uop_s1_i(uop_s1_i),
        .uop_s1_v_i(uop_s1_v_i), .uop_s2_i(uop_s2_i), .uop_s2_v_i(uop_s2_v_i),
        .uop_payload_i(uop_payload_i), .issue_v_o(issue_v_o), .fu_ready_i(fu_ready_i),
        .issue_dest_o(issue_dest_o), .issue_we_o(issue_we_o), .issue_flags_w_o(issue_flags_w_o),
        .issue_payload_o(issue_payload_o), .wb_v_i(wb_v_i), .wb_we_i(wb_we_i),
        .wb_dest_i(wb_dest_i), .wb_flags_i(wb_flags_i), .flush_i(flush_i), .stall_cnt_o(stall_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        foreach (rb[i]) rb[i] = 0;
        fb = '0;
        stall = '0;
    endtask

    // One model cycle: predict outputs from the current state and inputs, then advance.
    task automatic model_step();
        uop_t op, nu;
        bit hv, haz, vf, fire, rdy;
        logic [5:0] ei;
        hv = exp_q.size() > 0;
        op = hv ? exp_q[0] : '{default: 0};
        haz = (op.s1v && rb[op.s1]) || (op.s2v && rb[op.s2]) || (op.we && rb[op.dest]) ||
              (((op.fr | op.fw) & fb) != 4'd0);
        vf = op.fu < 3'd6;
        ei = (hv && !haz && vf) ? 6'(1 << op.fu) : 6'd0;
        fire = hv && !flush_i && (vf ? (!haz && fu_ready_i[op.fu]) : 1'b1);
        rdy = !flush_i && (!hv || fire);
        chk("issue_v", 32'(issue_v_o), 32'(ei));
        chk("uop_ready", 32'(uop_ready_o), 32'(rdy));
        chk("stall_cnt", 32'(stall_cnt_o), 32'(stall));
        if (hv) begin
            chk("issue_dest", 32'(issue_dest_o), 32'(op.dest));
            chk("issue_we", 32'(issue_we_o), 32'(op.we));
            chk("issue_flags_w", 32'(issue_flags_w_o), 32'(op.fw));
            chk("issue_payload", issue_payload_o, op.pl);
        end
        if (wb_v_i && wb_we_i) rb[wb_dest_i] = 0;
        if (wb_v_i) fb = fb & ~wb_flags_i;
        if (fire) begin
            if (vf) begin
                if (op.we) rb[op.dest] = 1;
                fb = fb | op.fw;
            end
            void'(exp_q.pop_front());
        end else if (flush_i && hv) void'(exp_q.pop_front());
        else if (hv && stall != 16'hFFFF) stall = stall + 16'd1;
        if (uop_v_i && rdy) begin
            nu.we = uop_we_i; nu.fu = uop_fu_i; nu.fw = uop_flags_w_i; nu.fr = uop_flags_r_i;
            nu.dest = uop_dest_i; nu.s1 = uop_s1_i; nu.s1v = uop_s1_v_i;
            nu.s2 = uop_s2_i; nu.s2v = uop_s2_v_i; nu.pl = uop_payload_i;
            exp_q.push_back(nu);
        end
    endtask

    initial forever begin
        @(negedge clk_i);
        #4;
        if (!reset_n_i) model_reset();
        else model_step();
    end

    task automatic clear();
        uop_v_i = 0; uop_we_i = 0; uop_fu_i = 0; uop_flags_w_i = 0; uop_flags_r_i = 0;
        uop_dest_i = 0; uop_s1_i = 0; uop_s1_v_i = 0; uop_s2_i = 0; uop_s2_v_i = 0;
        uop_payload_i = 0; fu_ready_i = 6'h3F; wb_v_i = 0; wb_we_i = 0; wb_dest_i = 0;
        wb_flags_i = 0; flush_i = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk_i);
            clear();
        end
    endtask

    task automatic send(input logic we, input logic [2:0] fu, input logic [3:0] fw, input logic [3:0] fr,
                        input logic [3:0] dest, input logic [3:0] s1, input logic s1v,
                        input logic [3:0] s2, input logic s2v, input logic [31:0] pl);
        @(negedge clk_i);
        clear();
        uop_v_i = 1; uop_we_i = we; uop_fu_i = fu; uop_flags_w_i = fw; uop_flags_r_i = fr;
        uop_dest_i = dest; uop_s1_i = s1; uop_s1_v_i = s1v; uop_s2_i = s2; uop_s2_v_i = s2v;
        uop_payload_i = pl;
    endtask

    task automatic wb(input logic we, input logic [3:0] dest, input logic [3:0] flags);
        @(negedge clk_i);
        clear();
        wb_v_i = 1; wb_we_i = we; wb_dest_i = dest; wb_flags_i = flags;
    endtask

    initial begin
        clear();
        reset_n_i = 0;
        idle(2);
        chk("rst_issue_v", 32'(issue_v_o), 0);
        chk("rst_stall", 32'(stall_cnt_o), 0);
        chk("rst_dest", 32'(issue_dest_o), 0);
        chk("rst_we", 32'(issue_we_o), 0);
        chk("rst_flags_w", 32'(issue_flags_w_o), 0);
        chk("rst_payload", issue_payload_o, 0);
        @(negedge clk_i);
        reset_n_i = 1;
        send(1, 1, 4'hF, 0, 1, 2, 1, 3, 1, 32'hADD0_0001);
        idle(2);
        send(1, 0, 0, 0, 4, 1, 1, 0, 0, 32'h0000_404D);
        idle(4);
        wb(1, 1, 4'hF);
        idle(3);
        send(0, 1, 4'hF, 0, 0, 2, 1, 3, 1, 32'h0000_0C3B);
        send(0, 5, 0, 4'b0100, 0, 0, 0, 0, 0, 32'h0000_0B0C);
        idle(3);
        wb(0, 0, 4'b0100);
        idle(2);
        send(1, 1, 0, 0, 5, 9, 1, 10, 1, 32'h1111_0005);
        send(1, 3, 0, 0, 6, 11, 1, 12, 0, 32'h2222_0006);
        send(1, 4, 0, 0, 7, 13, 1, 14, 1, 32'h3333_0007);
        send(1, 2, 0, 0, 8, 0, 0, 0, 0, 32'h4444_0008);
        repeat (4) begin
            @(negedge clk_i);
            clear();
            fu_ready_i = 6'b111011;
        end
        idle(2);
        send(1, 7, 4'hF, 0, 9, 0, 0, 0, 0, 32'h7777_7777);
        idle(2);
        send(1, 0, 0, 0, 10, 5, 1, 0, 0, 32'h5555_F1F1);
        idle(2);
        @(negedge clk_i);
        clear();
        flush_i = 1;
        idle(2);
        send(1, 1, 0, 0, 11, 6, 1, 0, 0, 32'h6666_A5A5);
        idle(3);
        @(negedge clk_i);
        #2 reset_n_i = 0;
        #1;
        chk("async_issue_v", 32'(issue_v_o), 0);
        chk("async_stall", 32'(stall_cnt_o), 0);
        chk("async_payload", issue_payload_o, 0);
        idle(2);
        reset_n_i = 1;
        repeat (3000) begin
            @(negedge clk_i);
            clear();
            uop_v_i = 1'($urandom_range(0, 3) != 0);
            uop_we_i = 1'($urandom_range(0, 1));
            uop_fu_i = ($urandom_range(0, 9) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
            uop_flags_w_i = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            uop_flags_r_i = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            uop_dest_i = 4'($urandom_range(0, 15));
            uop_s1_i = 4'($urandom_range(0, 15));
            uop_s1_v_i = 1'($urandom_range(0, 1));
            uop_s2_i = 4'($urandom_range(0, 15));
            uop_s2_v_i = 1'($urandom_range(0, 1));
            uop_payload_i = $urandom;
            for (int i = 0; i < 6; i++) fu_ready_i[i] = ($urandom_range(0, 3) != 0);
            wb_v_i = 1'($urandom_range(0, 1));
            wb_we_i = 1'($urandom_range(0, 3) != 0);
            wb_dest_i = 4'($urandom_range(0, 15));
            wb_flags_i = 4'($urandom_range(0, 15));
            flush_i = ($urandom_range(0, 15) == 0);
        end
        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
